// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman host driver: base codes, score bias and FSM states.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_G = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    localparam int SW_SCORE_WIDTH = 12;

    // Scores in the chain are offset by half the range so that zero sits mid-scale.
    function automatic int zero_bias(input int width);
        return 1 << (width - 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_GAP,
        ST_WAIT_RES,
        ST_RESULT
    } drv_state_e;

endpackage

// File: rtl/sw_base_buffer.sv
// Target base store: one write port, one registered read port (1-cycle read latency).
module sw_base_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            rd_data
);

    logic [1:0] mem [2**ADDR_WIDTH];
    logic [1:0] rd_data_q;

    // No reset here so the array maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sw_chain_driver.sv
// Host-side end of the systolic PE chain: buffers a target, streams it into the
// first PE, then returns the tail score (or a timeout) over a valid/ready handshake.
import sw_pkg::*;

module sw_chain_driver #(
    parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int ADDR_WIDTH  = 10,
    parameter int ZERO        = zero_bias(SCORE_WIDTH),
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [1:0]             ld_base,
    input  logic                   ld_last,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic [SCORE_WIDTH-1:0] tail_High,
    input  logic                   tail_vld,
    output logic                   sc_valid,
    input  logic                   sc_ready,
    output logic [SCORE_WIDTH-1:0] sc_score,
    output logic                   sc_timeout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SCORE_WIDTH-1:0] ZERO_V  = SCORE_WIDTH'(ZERO);
    localparam logic [PTR_W-1:0]       PTR_TOP = PTR_W'((1 << ADDR_WIDTH) - 1);
    localparam logic [PTR_W-1:0]       PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]       CNT_TC  = CNT_W'(TIMEOUT - 1);

    drv_state_e             state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ld_ready_q, ld_ready_d;
    logic                   pe_en_q, pe_en_d;
    logic                   sc_valid_q, sc_valid_d;
    logic [SCORE_WIDTH-1:0] sc_score_q, sc_score_d;
    logic                   sc_timeout_q, sc_timeout_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;

    logic                   ld_hs;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   rd_en;
    logic [1:0]             rd_data;

    assign ld_hs = ld_valid & ld_ready_q;

    sw_base_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (ld_base),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        pe_en_d      = 1'b0;
        sc_valid_d   = sc_valid_q;
        sc_score_d   = sc_score_q;
        sc_timeout_d = sc_timeout_q;
        ovf_d        = ovf_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[ADDR_WIDTH-1:0];
        rd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_hs) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    ovf_d    = 1'b0;
                    rd_ptr_d = '0;
                    if (ld_last) begin
                        len_d    = PTR_ONE;
                        wr_ptr_d = '0;
                        state_d  = ST_STREAM;
                    end else begin
                        wr_ptr_d = PTR_ONE;
                        state_d  = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (ld_hs) begin
                    wr_en = 1'b1;
                    // A full buffer is closed out as if the host had flagged the last base.
                    if (ld_last || wr_ptr_q == PTR_TOP) begin
                        len_d    = wr_ptr_q + PTR_ONE;
                        rd_ptr_d = '0;
                        state_d  = ST_STREAM;
                        if (!ld_last) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end

            ST_STREAM: begin
                // pe_en is registered alongside the RAM read so enable and data line up.
                if (rd_ptr_q != len_q) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    pe_en_d  = 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                cnt_d   = '0;
                state_d = ST_WAIT_RES;
            end

            ST_WAIT_RES: begin
                if (tail_vld) begin
                    sc_score_d   = tail_High;
                    sc_timeout_d = 1'b0;
                    sc_valid_d   = 1'b1;
                    state_d      = ST_RESULT;
                end else if (cnt_q == CNT_TC) begin
                    sc_score_d   = ZERO_V;
                    sc_timeout_d = 1'b1;
                    sc_valid_d   = 1'b1;
                    state_d      = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESULT: begin
                if (sc_ready && sc_valid_q) begin
                    sc_valid_d   = 1'b0;
                    sc_timeout_d = 1'b0;
                    wr_ptr_d     = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ld_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d     = !ld_ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            ld_ready_q   <= 1'b0;
            pe_en_q      <= 1'b0;
            sc_valid_q   <= 1'b0;
            sc_score_q   <= ZERO_V;
            sc_timeout_q <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ld_ready_q   <= ld_ready_d;
            pe_en_q      <= pe_en_d;
            sc_valid_q   <= sc_valid_d;
            sc_score_q   <= sc_score_d;
            sc_timeout_q <= sc_timeout_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign pe_en      = pe_en_q;
    assign pe_data    = pe_en_q ? rd_data : BASE_A;
    assign pe_M       = ZERO_V;
    assign pe_I       = ZERO_V;
    assign pe_High    = ZERO_V;
    assign sc_valid   = sc_valid_q;
    assign sc_score   = sc_score_q;
    assign sc_timeout = sc_timeout_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sw_chain_driver.sv
// Directed bench for sw_chain_driver with a 4-entry buffer and a 16-cycle result timeout.
import sw_pkg::*;

module tb_sw_chain_driver;

    localparam int SW = 12;
    localparam int AW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [1:0]    ld_base = 2'b00;
    logic          ld_last = 1'b0;
    logic          pe_en;
    logic [1:0]    pe_data;
    logic [SW-1:0] pe_M, pe_I, pe_High;
    logic [SW-1:0] tail_High = '0;
    logic          tail_vld = 1'b0;
    logic          sc_valid;
    logic          sc_ready = 1'b0;
    logic [SW-1:0] sc_score;
    logic          sc_timeout;
    logic          ovf;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_b [8];

    sw_chain_driver #(
        .SCORE_WIDTH(SW),
        .ADDR_WIDTH (AW),
        .ZERO       (2048),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_base    (ld_base),
        .ld_last    (ld_last),
        .pe_en      (pe_en),
        .pe_data    (pe_data),
        .pe_M       (pe_M),
        .pe_I       (pe_I),
        .pe_High    (pe_High),
        .tail_High  (tail_High),
        .tail_vld   (tail_vld),
        .sc_valid   (sc_valid),
        .sc_ready   (sc_ready),
        .sc_score   (sc_score),
        .sc_timeout (sc_timeout),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle k counts negedges after the last-base handshake edge.
    task automatic chk_stream(input string tag, input int k, input int len);
        logic en;
        logic [1:0] d;
        en = (k >= 2) && (k <= len + 1);
        d  = en ? exp_b[k-2] : 2'b00;
        chk($sformatf("%s pe_en k=%0d", tag, k), 32'(pe_en), 32'(en));
        chk($sformatf("%s pe_data k=%0d", tag, k), 32'(pe_data), 32'(d));
    endtask

    task automatic load_seq(input int n, input bit with_last);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_base  = exp_b[i];
            ld_last  = with_last && (i == n - 1);
            w = 0;
            while (!ld_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!ld_ready) chk("ld_ready wait", 32'(ld_ready), 32'd1);
            @(posedge clk);
            #1;
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
    endtask

    task automatic finish_run(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!sc_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " sc_valid"}, 32'(sc_valid), 32'd1);
        sc_ready = 1'b1;
        @(posedge clk);
        #1;
        sc_ready = 1'b0;
        @(negedge clk);
        chk({tag, " sc_valid cleared"}, 32'(sc_valid), 32'd0);
        chk({tag, " ld_ready idle"}, 32'(ld_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst ld_ready", 32'(ld_ready), 32'd0);
        chk("rst pe_en", 32'(pe_en), 32'd0);
        chk("rst pe_data", 32'(pe_data), 32'd0);
        chk("rst sc_valid", 32'(sc_valid), 32'd0);
        chk("rst sc_score", 32'(sc_score), 32'h800);
        chk("rst sc_timeout", 32'(sc_timeout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst pe_M", 32'(pe_M), 32'h800);
        chk("rst pe_I", 32'(pe_I), 32'h800);
        chk("rst pe_High", 32'(pe_High), 32'h800);
        rst = 1'b0;
        @(negedge clk);
        chk("idle ld_ready", 32'(ld_ready), 32'd1);

        // Test 1: AGTC stream, no tail_vld -> timeout 16 cycles after WAIT_RES entry (k=7)
        exp_b[0] = BASE_A; exp_b[1] = BASE_G; exp_b[2] = BASE_T; exp_b[3] = BASE_C;
        load_seq(4, 1'b1);
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k <= 7) chk_stream("t1", k, 4);
            if (k == 3) begin
                chk("t1 pe_M", 32'(pe_M), 32'h800);
                chk("t1 pe_I", 32'(pe_I), 32'h800);
                chk("t1 pe_High", 32'(pe_High), 32'h800);
                chk("t1 ld_ready stream", 32'(ld_ready), 32'd0);
                chk("t1 busy", 32'(busy), 32'd1);
            end
            if (k == 22) chk("t1 sc_valid early", 32'(sc_valid), 32'd0);
        end
        chk("t1 sc_valid", 32'(sc_valid), 32'd1);
        chk("t1 sc_timeout", 32'(sc_timeout), 32'd1);
        chk("t1 sc_score", 32'(sc_score), 32'h800);
        sc_ready = 1'b1;
        @(posedge clk);
        #1;
        sc_ready = 1'b0;
        @(negedge clk);
        chk("t1 ack sc_valid", 32'(sc_valid), 32'd0);
        chk("t1 ack sc_timeout", 32'(sc_timeout), 32'd0);
        chk("t1 ack ld_ready", 32'(ld_ready), 32'd1);
        chk("t1 ack busy", 32'(busy), 32'd0);

        // Test 2: tail_vld 7 cycles after pe_en falls (k=6) -> captured score, held under backpressure
        load_seq(4, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 7) chk_stream("t2", k, 4);
            if (k == 13) begin
                tail_vld  = 1'b1;
                tail_High = 12'h80A;
                chk("t2 sc_valid before", 32'(sc_valid), 32'd0);
            end
            if (k == 14) tail_vld = 1'b0;
            if (k >= 14) begin
                chk($sformatf("t2 sc_valid k=%0d", k), 32'(sc_valid), 32'd1);
                chk($sformatf("t2 sc_score k=%0d", k), 32'(sc_score), 32'h80A);
                chk($sformatf("t2 sc_timeout k=%0d", k), 32'(sc_timeout), 32'd0);
            end
        end
        sc_ready = 1'b1;
        @(posedge clk);
        #1;
        sc_ready = 1'b0;
        @(negedge clk);
        chk("t2 ack sc_valid", 32'(sc_valid), 32'd0);
        chk("t2 ack ld_ready", 32'(ld_ready), 32'd1);

        // Test 3: buffer full without ld_last -> ovf, exactly 4 bases, extra ld_valid refused
        exp_b[0] = BASE_G; exp_b[1] = BASE_T; exp_b[2] = BASE_C; exp_b[3] = BASE_A;
        load_seq(4, 1'b0);
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ld_valid = 1'b1;
                ld_base  = BASE_C;
            end
            if (k == 7) ld_valid = 1'b0;
            chk_stream("t3", k, 4);
            if (k <= 6) chk($sformatf("t3 ld_ready k=%0d", k), 32'(ld_ready), 32'd0);
            if (pe_en) cnt++;
        end
        chk("t3 ovf", 32'(ovf), 32'd1);
        chk("t3 pe_en count", 32'(cnt), 32'd4);
        finish_run("t3");
        chk("t3 ovf sticky", 32'(ovf), 32'd1);

        // Test 6: stray tail_vld through LOAD, STREAM and GAP ignored; only 0x8FF in WAIT_RES captured
        exp_b[0] = BASE_C; exp_b[1] = BASE_C; exp_b[2] = BASE_G;
        tail_vld  = 1'b1;
        tail_High = 12'h123;
        load_seq(3, 1'b1);
        chk("t6 ovf cleared", 32'(ovf), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) tail_vld = 1'b0;
            if (k <= 6) chk_stream("t6", k, 3);
            if (k <= 9) chk($sformatf("t6 sc_valid k=%0d", k), 32'(sc_valid), 32'd0);
            if (k == 9) begin
                tail_vld  = 1'b1;
                tail_High = 12'h8FF;
            end
            if (k == 10) tail_vld = 1'b0;
        end
        chk("t6 sc_valid", 32'(sc_valid), 32'd1);
        chk("t6 sc_score", 32'(sc_score), 32'h8FF);
        chk("t6 sc_timeout", 32'(sc_timeout), 32'd0);
        finish_run("t6");

        // Test 5: reset in the 2nd STREAM cycle, then a 1-base load
        exp_b[0] = BASE_A; exp_b[1] = BASE_G; exp_b[2] = BASE_T; exp_b[3] = BASE_C;
        load_seq(4, 1'b1);
        @(negedge clk);
        chk("t5 pe_en k=1", 32'(pe_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 rst pe_en", 32'(pe_en), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst ld_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_b[0] = BASE_T;
        load_seq(1, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk_stream("t5", k, 1);
            if (pe_en) cnt++;
        end
        chk("t5 pe_en count", 32'(cnt), 32'd1);
        finish_run("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
